twiddle_gen: RTL and testbench

- Parametrised streaming twiddle-factor generator for radix-2 DIT FFT stages; successor to the combinational twiddle lookup.
- Stores only a quarter-wave cosine table and derives W_N^k = cos(2πk/N) − j·sin(2πk/N) by symmetry.
- On a start command for a given stage, emits one twiddle per butterfly (N/2 words) in butterfly order over a valid/ready stream.
- Feeds the butterfly datapath directly.

---
 rtl/twiddle_gen.sv | 175 +++++++++++++++++
 tb/tb_twiddle_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen.sv
// Streaming radix-2 DIT twiddle generator: W_N^k derived from a quarter-wave cosine table.
// Define TWIDDLE_CONJ_EN to add the 'inverse' input, which emits conj(W) for IFFT stages.
module twiddle_gen #(
  parameter int    DATA_WIDTH = 16,
  parameter int    N          = 16,
  parameter string INIT_FILE  = "twiddle_q.hex",
  localparam int   LOG2N      = $clog2(N),
  localparam int   SW         = $clog2(LOG2N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [SW-1:0]                stage,
`ifdef TWIDDLE_CONJ_EN
  input  logic                         inverse,
`endif
  output logic                         busy,
  output logic                         err,
  output logic                         tw_valid,
  input  logic                         tw_ready,
  output logic signed [DATA_WIDTH-1:0] tw_real,
  output logic signed [DATA_WIDTH-1:0] tw_imag,
  output logic [LOG2N-2:0]             tw_index,
  output logic                         tw_last
);

  localparam int              BW    = LOG2N - 1;
  localparam int              Q     = N / 4;
  localparam int              AW    = $clog2(Q + 1);
  localparam logic [BW-1:0]   QK    = BW'(Q);
  localparam logic [BW:0]     HALF  = (BW+1)'(N / 2);
  localparam logic [BW-1:0]   BLAST = BW'(N / 2 - 1);
  localparam logic [SW:0]     NSTG  = (SW+1)'(LOG2N);
  localparam logic [SW:0]     BWS   = (SW+1)'(BW);

  function automatic logic signed [DATA_WIDTH-1:0] cos_q(input int i);
    real a;
    real fs;
    a  = (2.0 * 3.14159265358979323846 * i) / N;
    fs = real'((1 << (DATA_WIDTH - 1)) - 1);
    return DATA_WIDTH'($rtoi(fs * $cos(a) + 0.5));
  endfunction

  // Saturating negate; the table never holds the most negative code, but stay safe.
  function automatic logic signed [DATA_WIDTH-1:0] sat_neg(input logic signed [DATA_WIDTH-1:0] x);
    if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}})
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return -x;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(input logic signed [DATA_WIDTH-1:0] x,
                                                              input logic neg);
    return neg ? sat_neg(x) : x;
  endfunction

  logic signed [DATA_WIDTH-1:0] rom [0:Q];

  generate
    for (genvar i = 0; i <= Q; i++) begin : g_ent
      assign rom[i] = cos_q(i);
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] b_q;
  logic [SW-1:0] stage_q;
  logic          inv_q, inv_in;
  logic          en, accept, reject, issue, fin;

`ifdef TWIDDLE_CONJ_EN
  assign inv_in = inverse;
`else
  assign inv_in = 1'b0;
`endif

  assign en     = !tw_valid || tw_ready;
  assign accept = (state_q == IDLE) && start && ({1'b0, stage} < NSTG);
  assign reject = (state_q == IDLE) && start && !({1'b0, stage} < NSTG);
  assign issue  = (state_q == RUN) && en;
  assign fin    = tw_valid && tw_ready && tw_last;
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (issue && (b_q == BLAST)) state_d = DRAIN;
      DRAIN:   if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      err     <= reject;
      if (accept) begin
        b_q     <= '0;
        stage_q <= stage;
        inv_q   <= inv_in;
      end else if (issue) begin
        b_q <= b_q + BW'(1);
      end
    end
  end

  // Butterfly b -> exponent k = (b mod 2^s) << (LOG2N-1-s), then fold into the quarter wave.
  logic [BW-1:0] j_c, k_c;
  logic          quad_c;
  logic [AW-1:0] are_c, aim_c;

  always_comb begin
    j_c    = b_q & ~({BW{1'b1}} << stage_q);
    k_c    = j_c << (BWS - {1'b0, stage_q});
    quad_c = (k_c > QK);
    are_c  = quad_c ? AW'(HALF - {1'b0, k_c}) : AW'(k_c);
    aim_c  = quad_c ? AW'(k_c - QK) : AW'(QK - k_c);
  end

  // ---- P1: exponent, quadrant and table addresses
  logic          vld_p1, last_p1, quad_p1;
  logic [BW-1:0] k_p1;
  logic [AW-1:0] are_p1, aim_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (en) begin
      vld_p1  <= (state_q == RUN);
      last_p1 <= (state_q == RUN) && (b_q == BLAST);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      k_p1    <= k_c;
      quad_p1 <= quad_c;
      are_p1  <= are_c;
      aim_p1  <= aim_c;
    end
  end

  // ---- P2: synchronous table read with sign applied; these are the stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_valid <= 1'b0;
      tw_last  <= 1'b0;
      tw_real  <= '0;
      tw_imag  <= '0;
      tw_index <= '0;
    end else if (en) begin
      tw_valid <= vld_p1;
      tw_last  <= last_p1;
      if (vld_p1) begin
        tw_real  <= apply_sign(rom[are_p1], quad_p1);
        tw_imag  <= apply_sign(rom[aim_p1], !inv_q);
        tw_index <= k_p1;
      end else begin
        tw_real  <= '0;
        tw_imag  <= '0;
        tw_index <= '0;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen: N=16 stream checks plus an N=32 instance for stage rejection.
`timescale 1ns/1ps
module tb_twiddle_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, start, tw_ready;
  logic [1:0]         stage;
  logic               busy, err, tw_valid, tw_last;
  logic signed [15:0] tw_real, tw_imag;
  logic [2:0]         tw_index;

  logic               start32, tw_ready32;
  logic [2:0]         stage32;
  logic               busy32, err32, tw_valid32, tw_last32;
  logic signed [15:0] tw_real32, tw_imag32;
  logic [3:0]         tw_index32;

`ifdef TWIDDLE_CONJ_EN
  logic inverse, inverse32;
`endif

  twiddle_gen #(.DATA_WIDTH(16), .N(16), .INIT_FILE("")) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage),
`ifdef TWIDDLE_CONJ_EN
    .inverse(inverse),
`endif
    .busy(busy), .err(err), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_real(tw_real), .tw_imag(tw_imag), .tw_index(tw_index), .tw_last(tw_last)
  );

  twiddle_gen #(.DATA_WIDTH(16), .N(32), .INIT_FILE("")) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .stage(stage32),
`ifdef TWIDDLE_CONJ_EN
    .inverse(inverse32),
`endif
    .busy(busy32), .err(err32), .tw_valid(tw_valid32), .tw_ready(tw_ready32),
    .tw_real(tw_real32), .tw_imag(tw_imag32), .tw_index(tw_index32), .tw_last(tw_last32)
  );

  // Hand-computed N=16, Q15 twiddles indexed by k.
  int re_tab [8] = '{32767, 30273, 23170, 12539, 0, -12539, -23170, -30273};
  int im_tab [8] = '{0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stage(input int s, input bit rnd, input bit inv, input bit poke);
    int got, cyc, first, k;
    bit held, ext;
    logic signed [15:0] h_re, h_im;
    logic [2:0] h_idx;
    logic h_last;
    got = 0; cyc = 0; first = -1; held = 1'b0;
    h_re = '0; h_im = '0; h_idx = '0; h_last = 1'b0;
    start = 1'b1;
    stage = 2'(s);
`ifdef TWIDDLE_CONJ_EN
    inverse = inv;
`endif
    tw_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1);
    while (got < 8 && cyc < 300) begin
      tw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && cyc == 4) begin start = 1'b1; stage = 2'd1; end
      if (poke && cyc == 5) start = 1'b0;
      if (held) begin
        chk("stall_valid", tw_valid, 1);
        chk("stall_real", tw_real, h_re);
        chk("stall_imag", tw_imag, h_im);
        chk("stall_index", tw_index, h_idx);
        chk("stall_last", tw_last, h_last);
      end
      held = 1'b0;
      if (tw_valid === 1'b1) begin
        if (first < 0) first = cyc;
        if (tw_ready) begin
          k = (got & ((1 << s) - 1)) << (3 - s);
          chk("index", tw_index, k);
          chk("real", tw_real, re_tab[k]);
          chk("imag", tw_imag, inv ? -im_tab[k] : im_tab[k]);
          chk("last", tw_last, (got == 7) ? 1 : 0);
          if (poke && got == 7) begin start = 1'b1; stage = 2'd3; end
          got++;
        end else begin
          held = 1'b1;
          h_re = tw_real; h_im = tw_imag; h_idx = tw_index; h_last = tw_last;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("word_count", got, 8);
    if (!rnd) chk("first_latency", first, 3);
    chk("busy_end", busy, 0);
    chk("valid_end", tw_valid, 0);
    if (poke) begin
      ext = 1'b0;
      repeat (4) begin
        tick();
        ext = ext | busy | tw_valid;
      end
      chk("start_at_final_ignored", ext, 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, tw_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_real"}, tw_real, 0);
    chk({tag, "_imag"}, tw_imag, 0);
    chk({tag, "_index"}, tw_index, 0);
    chk({tag, "_last"}, tw_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stage = '0; tw_ready = 1'b1;
    start32 = 1'b0; stage32 = '0; tw_ready32 = 1'b1;
`ifdef TWIDDLE_CONJ_EN
    inverse = 1'b0; inverse32 = 1'b0;
`endif
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();

    run_stage(0, 1'b0, 1'b0, 1'b0);
    run_stage(3, 1'b0, 1'b0, 1'b0);
    run_stage(2, 1'b0, 1'b0, 1'b0);
    run_stage(1, 1'b0, 1'b0, 1'b0);
    run_stage(3, 1'b1, 1'b0, 1'b0);
    run_stage(3, 1'b0, 1'b0, 1'b1);

    // Out-of-range stage on the N=32 instance.
    start32 = 1'b1; stage32 = 3'd5;
    tick();
    start32 = 1'b0;
    chk("err32_pulse", err32, 1);
    chk("err32_busy", busy32, 0);
    tick();
    chk("err32_clear", err32, 0);
    chk("err32_busy2", busy32, 0);
    repeat (3) tick();
    chk("err32_no_valid", tw_valid32, 0);

    // Valid start on N=32 still works after a rejection.
    start32 = 1'b1; stage32 = 3'd4;
    tick();
    start32 = 1'b0;
    chk("n32_busy", busy32, 1);
    tick();
    tick();
    chk("n32_valid", tw_valid32, 1);
    chk("n32_real", tw_real32, 32767);
    chk("n32_imag", tw_imag32, 0);
    chk("n32_index", tw_index32, 0);
    for (int i = 0; i < 100 && busy32; i++) tick();
    chk("n32_busy_fall", busy32, 0);

    // Asynchronous reset in the middle of a stage.
    start = 1'b1; stage = 2'd3; tw_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_valid", tw_valid, 1);
    chk("pre_rst_real", tw_real, 23170);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", tw_valid, 0);
    chk("post_rst_busy", busy, 0);
    run_stage(3, 1'b0, 1'b0, 1'b0);

`ifdef TWIDDLE_CONJ_EN
    run_stage(3, 1'b0, 1'b1, 1'b0);
    run_stage(3, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
